demux_sched: RTL
================

# demux_sched

Round-robin scheduler and lane buffer for the byte demultiplexer path. Accepts a byte stream (valid/ready) on the fast clock, steers each accepted byte to the next enabled output lane, and holds it in a single-entry per-lane buffer until the lane consumer takes it. It drives the `control` lane-select word the demux datapath consumes. It also provides backpressure, lane masking, resynchronisation and an accepted-byte counter.

## Interface
- `DATA_WIDTH`, default 8: byte width.
- `LANES`, default 4: number of output lanes. The design is fixed at 4; the parameter exists for checking only.
- `clk` in 1: single clock (the 1 MHz domain); all logic on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `valid_in` in 1: upstream byte valid.
- `data_in` in 8: upstream byte.
- `ready_out` out 1: upstream accept. A byte transfers when `valid_in & ready_out`.
- `sync_in` in 1: realign; forces the next byte to lane 0.
- `lane_en` in 4: per-lane enable mask.
- `lane_ready` in 4: per-lane consumer ready.
- `lane_valid` out 4: per-lane buffer occupied.
- `lane_data` out 32: lane k is on bits [8k+7:8k].
- `control` out 8: {2'b00, state[1:0], one-hot pointer[3:0]}.
- `byte_count` out 16: accepted-byte counter; wraps modulo 2^16.

## Operation
- Internal state:
  - `ptr` (0..3): target lane for the next byte.
  - `full[3:0]`: per-lane occupancy, equal to `lane_valid`.
  - FSM with states IDLE=2'd0, RUN=2'd1, STALL=2'd2.
- Drain: when `lane_valid[k] & lane_ready[k]`, `full[k]` clears at the next edge.
  - Applies regardless of `lane_en[k]`; a disabled lane still drains its held byte.
- Accept condition: `ready_out = (state != IDLE) & lane_en[ptr] & (!full[ptr] | lane_ready[ptr])`.
  - Combinational from `lane_ready`. A full lane drained in the same cycle accepts a new byte, so sustained throughput is 1 byte/cycle.
- On accept:
  - `lane_data[ptr]` is loaded with `data_in` and `full[ptr]` is set.
  - `ptr` moves to the next enabled lane after `ptr`, searching circularly (ptr+1, ptr+2, ptr+3, ptr).
  - If only one lane is enabled, `ptr` stays on it.
  - `byte_count` increments.
- Pointer repair: if `lane_en[ptr]==0` and the mask is non-zero, `ptr` moves to the next enabled lane at the next edge, with no byte transferred in that cycle.
- `sync_in`:
  - Sets `ptr` to 0 at the next edge.
  - If asserted together with an accept, the accepted byte goes to the current `ptr` as normal, and the next byte targets lane 0.
  - If lane 0 is disabled, pointer repair then applies from lane 0.
- FSM transitions, evaluated each cycle, first match wins:
  - `lane_en==0` goes to IDLE.
  - From IDLE with a non-zero mask, go to RUN.
  - From RUN, go to STALL when `valid_in & lane_en[ptr] & full[ptr] & !lane_ready[ptr]`.
  - From STALL, return to RUN when `!full[ptr] | lane_ready[ptr]`.
  - A mask change that moves `ptr` to a non-full lane also returns STALL to RUN.
- Byte ordering: bytes arrive at lanes in strict circular order over the enabled lanes. No byte is dropped or duplicated while `reset` is low.

## Timing
- Reset values:
  - `ready_out`=0, `lane_valid`=0, `lane_data`=0, `byte_count`=0.
  - `ptr`=0, state IDLE, `control`=8'h01.
- IDLE lasts at least 1 cycle after reset deasserts. With `lane_en` non-zero, the first accept can occur in cycle 2 after reset release.
- Latency: a byte accepted at edge N appears on `lane_data[k]` with `lane_valid[k]=1` after edge N (visible in cycle N+1).
- Lane data is held stable while `lane_valid[k] & !lane_ready[k]`.
- Simultaneous drain and load on the same lane in one cycle: `lane_valid` stays 1 and the data updates to the new byte.
- `control` is registered and reflects `ptr` and state after each edge.
- Reset asserted mid-operation: all buffered bytes are discarded, and outputs take reset values at the next edge.
- `byte_count` rolls from 16'hFFFF to 16'h0000 without any flag.

## Test plan
- Reset then `lane_en`=4'hF, all `lane_ready`=1, bytes 8'hA0..8'hA7 back-to-back -> lanes 0,1,2,3,0,1,2,3 receive A0..A7; `ready_out` stays 1; `byte_count`=8.
- `lane_en`=4'b1010, bytes 8'h10..8'h13 -> lanes 1,3,1,3 receive 10,11,12,13; lanes 0 and 2 stay invalid.
- `lane_ready[2]`=0, stream 8 bytes -> third byte is held in lane 2. On the 7th byte (lane 2 again), state becomes STALL, `control[5:4]`=2'b10 and `ready_out`=0. Raising `lane_ready[2]` resumes in the same cycle with no loss.
- After 2 bytes (ptr=2), pulse `sync_in` with no valid -> `control[3:0]`=4'b0001; the next byte 8'h55 goes to lane 0.
- `lane_en` changed 4'hF to 4'h0 mid-stream -> IDLE, `ready_out`=0, existing full lanes still drain. Restoring the mask resumes at the next enabled lane after `ptr`.
- Preload `byte_count` to 16'hFFFE via 65534 accepts, then accept 3 -> count reads 16'h0001; assert `reset` while lanes are full -> all `lane_valid`=0 the next cycle.

Source files
------------

// File: rtl/demux_sched_if.sv
// Byte-stream and lane-buffer signals between the demux scheduler and its
// upstream source / lane consumers.
interface demux_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
);
  logic                          valid_in;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          ready_out;
  logic                          sync_in;
  logic [LANES-1:0]              lane_en;
  logic [LANES-1:0]              lane_ready;
  logic [LANES-1:0]              lane_valid;
  logic [LANES*DATA_WIDTH-1:0]   lane_data;
  logic [7:0]                    control;
  logic [15:0]                   byte_count;

  // Scheduler side
  modport slave (
    input  valid_in, data_in, sync_in, lane_en, lane_ready,
    output ready_out, lane_valid, lane_data, control, byte_count
  );

  // Source / consumer side
  modport master (
    output valid_in, data_in, sync_in, lane_en, lane_ready,
    input  ready_out, lane_valid, lane_data, control, byte_count
  );
endinterface

// File: rtl/demux_sched.sv
// Round-robin lane scheduler with a single-entry buffer per output lane.
// Accepted bytes are steered to the next enabled lane in circular order and
// held until the lane consumer takes them.
module demux_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
) (
  input  logic          clk,
  input  logic          reset,
  demux_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             ptr_q, ptr_d;
  logic [3:0]             full_q, full_d;
  logic [DATA_WIDTH-1:0]  data_q [4];
  logic [DATA_WIDTH-1:0]  data_d [4];
  logic [15:0]            count_q, count_d;
  logic [7:0]             control_q, control_d;
  logic                   ready;
  logic                   accept;
  logic [1:0]             next_ptr;

  // Nearest enabled lane after p, searching p+1, p+2, p+3; stays on p otherwise.
  function automatic logic [1:0] next_lane(input logic [1:0] p, input logic [3:0] en);
    logic [1:0] r;
    logic [1:0] idx;
    r = p;
    for (int d = 3; d >= 1; d--) begin
      idx = p + 2'(d);
      if (en[idx]) r = idx;
    end
    return r;
  endfunction

  // A full lane that is drained this same cycle can take a new byte.
  assign ready  = (state_q != IDLE) & bus.lane_en[ptr_q]
                & (~full_q[ptr_q] | bus.lane_ready[ptr_q]);
  assign accept = bus.valid_in & ready;
  assign next_ptr = next_lane(ptr_q, bus.lane_en);

  // Next-state logic: lane buffers, pointer, counter, FSM and control word.
  always_comb begin
    full_d  = full_q & ~bus.lane_ready;
    data_d  = data_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    state_d = state_q;

    if (accept) begin
      data_d[ptr_q] = bus.data_in;
      full_d[ptr_q] = 1'b1;
      count_d       = count_q + 16'd1;
    end

    // sync wins over advance/repair; a disabled lane 0 is repaired next cycle.
    if (bus.sync_in) begin
      ptr_d = 2'd0;
    end else if (accept || (bus.lane_en != 4'd0 && !bus.lane_en[ptr_q])) begin
      ptr_d = next_ptr;
    end

    if (bus.lane_en == 4'd0) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  state_d = RUN;
        RUN:   if (bus.valid_in && bus.lane_en[ptr_q] && full_q[ptr_q]
                   && !bus.lane_ready[ptr_q]) state_d = STALL;
        STALL: if (!full_q[ptr_q] || bus.lane_ready[ptr_q]) state_d = RUN;
               else if (!bus.lane_en[ptr_q]
                        && (!full_q[ptr_d] || bus.lane_ready[ptr_d])) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end

    control_d = {2'b00, state_d, 4'b0001 << ptr_d};
  end

  // State registers; reset discards any buffered bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      full_q    <= 4'd0;
      count_q   <= 16'd0;
      control_q <= 8'h01;
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      full_q    <= full_d;
      count_q   <= count_d;
      control_q <= control_d;
      data_q    <= data_d;
    end
  end

  assign bus.ready_out  = ready;
  assign bus.lane_valid = full_q;
  assign bus.control    = control_q;
  assign bus.byte_count = count_q;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign bus.lane_data[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
  end

endmodule
